alu: RTL and testbench



---
 rtl/alu_if.sv | 20 ++
 rtl/alu.sv | 62 ++++++
 tb/tb_alu.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/alu_if.sv
// rtl/alu_if.sv - operand/opcode request and registered result bundle for the alu
interface alu_if;
  logic        enable;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  opcode;
  logic        zf;
  logic        cf;
  logic [32:0] res;

  modport master (
    output enable, a, b, opcode,
    input  zf, cf, res
  );

  modport slave (
    input  enable, a, b, opcode,
    output zf, cf, res
  );
endinterface

// File: rtl/alu.sv
// rtl/alu.sv - 32-bit registered alu with carry/borrow and zero flags
module alu (
  input logic   clk,
  input logic   rst_n,
  alu_if.slave  bus
);
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_INC = 3'd2;
  localparam logic [2:0] OP_DEC = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_NOT = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  logic [32:0] op_a;
  logic [32:0] op_b;
  logic [32:0] next_res;
  logic        next_cf;
  logic        next_zf;
  logic [32:0] res_q;
  logic        cf_q;
  logic        zf_q;

  assign op_a = {1'b0, bus.a};
  assign op_b = {1'b0, bus.b};

  // Logic ops leave bit 32 clear, so the carry flag falls out as zero for them.
  always_comb begin
    next_res = 33'd0;
    case (bus.opcode)
      OP_ADD:  next_res = op_a + op_b;
      OP_SUB:  next_res = op_a - op_b;
      OP_INC:  next_res = op_a + 33'd1;
      OP_DEC:  next_res = op_a - 33'd1;
      OP_AND:  next_res = {1'b0, bus.a & bus.b};
      OP_OR:   next_res = {1'b0, bus.a | bus.b};
      OP_NOT:  next_res = {1'b0, ~bus.a};
      OP_XOR:  next_res = {1'b0, bus.a ^ bus.b};
      default: next_res = 33'd0;
    endcase
  end

  assign next_cf = next_res[32];
  assign next_zf = (next_res[31:0] == 32'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= 33'd0;
      cf_q  <= 1'b0;
      zf_q  <= 1'b1;
    end else if (bus.enable) begin
      res_q <= next_res;
      cf_q  <= next_cf;
      zf_q  <= next_zf;
    end
  end

  assign bus.res = res_q;
  assign bus.cf  = cf_q;
  assign bus.zf  = zf_q;
endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - scoreboard bench for alu with randomized and directed stimulus
module tb_alu;
  logic clk;
  logic rst_n;
  alu_if bus ();

  alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [32:0] res;
    logic        cf;
    logic        zf;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  logic [32:0] m_res = 33'd0;
  logic        m_cf  = 1'b0;
  logic        m_zf  = 1'b1;

  task automatic check(input string nm, input logic [32:0] act, input logic [32:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [32:0] ref_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint unsigned x, y, r;
    x = {32'd0, a};
    y = {32'd0, b};
    case (op)
      3'd0: r = x + y;
      3'd1: r = x - y;
      3'd2: r = x + 1;
      3'd3: r = x - 1;
      3'd4: r = x & y;
      3'd5: r = x | y;
      3'd6: r = x ^ 64'hFFFF_FFFF;
      default: r = x ^ y;
    endcase
    return r[32:0];
  endfunction

  // Drive one cycle of stimulus; the model state after the coming edge goes to the scoreboard.
  task automatic do_op(input logic en, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic has_exp, input logic [32:0] exp_res, input string nm);
    exp_t e;
    logic [32:0] r;
    @(negedge clk);
    bus.enable = en;
    bus.opcode = op;
    bus.a      = a;
    bus.b      = b;
    if (en) begin
      r     = has_exp ? exp_res : ref_fn(op, a, b);
      m_res = r;
      m_cf  = r[32];
      m_zf  = (r[31:0] == 32'd0);
    end
    e.res  = m_res;
    e.cf   = m_cf;
    e.zf   = m_zf;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({e.name, ".res"}, bus.res, e.res);
      check({e.name, ".cf"}, {32'd0, bus.cf}, {32'd0, e.cf});
      check({e.name, ".zf"}, {32'd0, bus.zf}, {32'd0, e.zf});
    end
  end

  task automatic check_reset_vals(input string nm);
    check({nm, ".res"}, bus.res, 33'd0);
    check({nm, ".cf"}, {32'd0, bus.cf}, 33'd0);
    check({nm, ".zf"}, {32'd0, bus.zf}, 33'd1);
  endtask

  logic [31:0] sweep_exp [8];
  string       sweep_nm  [8];

  initial begin
    logic [31:0] ra, rb;
    int wait_cnt;
    sweep_exp = '{32'h0000_00B4, 32'h0000_0096, 32'h0000_00A6, 32'h0000_00A4,
                  32'h0000_0005, 32'h0000_00AF, 32'hFFFF_FF5A, 32'h0000_00AA};
    sweep_nm  = '{"sweep_add", "sweep_sub", "sweep_inc", "sweep_dec",
                  "sweep_and", "sweep_or", "sweep_not", "sweep_xor"};

    rst_n      = 1'b0;
    bus.enable = 1'b1;
    bus.a      = $urandom;
    bus.b      = $urandom;
    bus.opcode = 3'($urandom_range(0, 7));
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset_hold");

    @(negedge clk);
    bus.enable = 1'b0;
    rst_n      = 1'b1;
    do_op(1'b0, 3'd0, $urandom, $urandom, 1'b0, 33'd0, "release_idle0");
    do_op(1'b0, 3'd1, $urandom, $urandom, 1'b0, 33'd0, "release_idle1");

    for (int i = 0; i < 8; i++)
      do_op(1'b1, 3'(i), 32'hA5, 32'h0F, 1'b1, {1'b0, sweep_exp[i]}, sweep_nm[i]);

    do_op(1'b1, 3'd0, 32'hFFFF_FFFF, 32'd1, 1'b1, 33'h1_0000_0000, "add_carry");
    do_op(1'b1, 3'd2, 32'hFFFF_FFFF, $urandom, 1'b1, 33'h1_0000_0000, "inc_carry");
    do_op(1'b1, 3'd1, 32'd0, 32'd1, 1'b1, 33'h1_FFFF_FFFF, "sub_borrow");
    do_op(1'b1, 3'd3, 32'd0, $urandom, 1'b1, 33'h1_FFFF_FFFF, "dec_borrow");
    do_op(1'b1, 3'd1, 32'd5, 32'd5, 1'b1, 33'd0, "sub_equal");

    do_op(1'b1, 3'd7, 32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 33'h0_1D3B_5977, "hold_xor");
    for (int i = 0; i < 3; i++)
      do_op(1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom, 1'b0, 33'd0, "hold_idle");
    do_op(1'b1, 3'd5, 32'hF000_0000, 32'h0000_000F, 1'b1, 33'h0_F000_000F, "hold_reenable");

    for (int i = 0; i < 4; i++)
      do_op(1'b1, 3'(i), 32'hA5, 32'h0F, 1'b1, {1'b0, sweep_exp[i]}, sweep_nm[i]);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    rst_n = 1'b1;
    m_res = 33'd0;
    m_cf  = 1'b0;
    m_zf  = 1'b1;
    for (int i = 4; i < 8; i++)
      do_op(1'b1, 3'(i), 32'hA5, 32'h0F, 1'b1, {1'b0, sweep_exp[i]}, sweep_nm[i]);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: ra = 32'd0;
        1: ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      do_op(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), ra, rb, 1'b0, 33'd0, "random");
    end

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    #2;
    if (exp_q.size() > 0) begin
      total_cnt++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
